// File: rtl/board_io_pkg.sv
// Shared constants and the 7-segment decode table for the board front-end.
package board_io_pkg;

    // Bit positions inside the combined anode/segment bus.
    localparam int ANODE_LSB = 8;
    localparam int DP_BIT    = 7;

    // All segments and the decimal point dark (active-low).
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Hex digit to active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// Time-multiplexed 7-segment scanner: a prescaler selects how long each digit
// stays lit, the digit index picks a nibble of the display word, and the
// decoded anode/segment pattern is registered so the pins change cleanly.
// Runs from the global reset only, so it keeps scanning while the CPU is held.
module seg7_scan
    import board_io_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   disp,
    output logic [DIGITS+7:0]     digi
);

    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DIGITS+7:0] digi_q, digi_d;
    logic [3:0]        nibble;

    // Prescaler wraps at SCAN_DIV-1 and then steps the digit index round-robin.
    always_comb begin
        pre_d = pre_q + 1'b1;
        idx_d = idx_q;
        if (pre_q == PRE_MAX) begin
            pre_d = '0;
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
    end

    // Select the current digit's nibble and build the next pin pattern.
    always_comb begin
        nibble = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nibble = disp[i*4 +: 4];
            end
        end
        digi_d = '1;
        digi_d[ANODE_LSB +: DIGITS] = ~(DIGITS'(1) << idx_q);
        digi_d[DP_BIT-1:0]          = hex_to_seg(nibble);
    end

    // Counters and output register; reset blanks the display.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q  <= '0;
            idx_q  <= '0;
            digi_q <= {{DIGITS{1'b1}}, SEG_BLANK};
        end else begin
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            digi_q <= digi_d;
        end
    end

    assign digi = digi_q;

endmodule

// File: rtl/board_io_ctrl.sv
// Board front-end between the FPGA pins and the single-cycle CPU: debounces the
// reset switch, produces a divided CPU step enable (no derived clocks), holds
// the CPU-written LED and display registers and drives the 7-segment scanner.
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int LED_W    = 8,
    parameter int CPU_DIV  = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sw_reset,
    output logic                cpu_ce,
    output logic                cpu_reset,
    input  logic                wr_en,
    input  logic                wr_sel,
    input  logic [4*DIGITS-1:0] wr_data,
    output logic [LED_W-1:0]    led,
    output logic [DIGITS+7:0]   digi
);

    localparam int DW    = 4 * DIGITS;
    localparam int DB_W  = $clog2(DEBOUNCE + 1);
    localparam int CNT_W = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
    localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CPU_DIV - 1);

    logic [1:0]       sync_q, sync_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             sw_db_q, sw_db_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             ce_q, ce_d;
    logic [DW-1:0]    disp_q, disp_d;
    logic [LED_W-1:0] led_q, led_d;

    // The debounced switch adds no extra latency on top of the debounce itself.
    assign cpu_reset = reset | sw_db_q;
    // Gating with cpu_reset stops stepping in the very cycle the CPU is held.
    assign cpu_ce    = ce_q & ~cpu_reset;
    assign led       = led_q;

    // Two-flop synchroniser, then accept the synchronised value only after
    // DEBOUNCE consecutive samples that all differ from the accepted state.
    always_comb begin
        sync_d   = {sync_q[0], sw_reset};
        sw_db_d  = sw_db_q;
        db_cnt_d = '0;
        if (sync_q[1] != sw_db_q) begin
            if (db_cnt_q == DB_MAX) begin
                sw_db_d = sync_q[1];
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Step divider: pulse on the last count of each period, held idle in reset.
    always_comb begin
        div_d = '0;
        ce_d  = 1'b0;
        if (!cpu_reset) begin
            ce_d  = (div_q == CNT_MAX);
            div_d = ce_d ? '0 : div_q + 1'b1;
        end
    end

    // CPU-visible registers: cleared by either reset, written only on a step.
    always_comb begin
        disp_d = disp_q;
        led_d  = led_q;
        if (cpu_reset) begin
            disp_d = '0;
            led_d  = '0;
        end else if (wr_en && cpu_ce) begin
            if (wr_sel) begin
                led_d = wr_data[LED_W-1:0];
            end else begin
                disp_d = wr_data;
            end
        end
    end

    // State registers for the switch path, divider and CPU registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            db_cnt_q <= '0;
            sw_db_q  <= 1'b0;
            div_q    <= '0;
            ce_q     <= 1'b0;
            disp_q   <= '0;
            led_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            db_cnt_q <= db_cnt_d;
            sw_db_q  <= sw_db_d;
            div_q    <= div_d;
            ce_q     <= ce_d;
            disp_q   <= disp_d;
            led_q    <= led_d;
        end
    end

    seg7_scan #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk   (clk),
        .reset (reset),
        .disp  (disp_q),
        .digi  (digi)
    );

endmodule
